fe_bf2ii_pipe: RTL and testbench
================================

# fe_bf2ii_pipe

Parametrised, pipelined successor of the serial radix-2² BF2II butterfly in the fe FFT datapath. It processes NCH independent complex lanes per beat and applies the trivial and 45° twiddles (W0, −j, W1, W3) selected by an internal sample counter. The counter is re-aligned to the frame by `i_sof`, and the transform direction is chosen at run time per frame. The block sits between the BF2I stage and the next twiddle multiplier.

## Interface
- NBW_IN, 8, input word width (signed)
- NBI_IN, 1, input integer bits
- NBW_OUT, NBW_IN+1, output word width
- NBI_OUT, NBI_IN+1, output integer bits
- NCH, 1, independent lanes sharing one counter (≥1)
- NBW_C, 2, sample counter width (≥2)
- BSEL, 1, MSB index of the 2-bit twiddle selector in the counter (1..NBW_C-1)
- RND_INF, 0, output rnd_sat rounding mode when trimming
- clk  in  1  clock
- rst_async_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- i_sof  in  1  first beat of frame; meaningful only with i_valid
- i_inv  in  1  direction (0 forward, 1 inverse); sampled on valid i_sof beat
- i_data  in  [NCH-1:0][1:0][1:0] × NBW_IN  lane, pair {x0,x1}, {I,Q}
- o_valid  out  1  output beat valid
- o_sof  out  1  i_sof delayed with the beat
- o_data  out  [NCH-1:0][1:0][1:0] × NBW_OUT  {y0,y1} per lane
- o_sat  out  1  sticky per-frame saturation flag (only with FE_BF2II_PIPE_SAT_FLAG_EN)

## Operation
- Counter `count`, NBW_C bits:
  - valid beat with i_sof: the beat uses count=0, then count←1.
  - valid beat without i_sof: the beat uses count, then count←count+1 (wraps).
  - no valid: hold.
- sel = count[BSEL:BSEL-1] of the beat being used.
- Direction `inv_q`:
  - valid i_sof beat: that beat uses i_inv, then inv_q←i_inv.
  - other beats use inv_q.
- Twiddled term t = W·x1; outputs y0 = x0 + t, y1 = x0 − t.
- Forward twiddles:
  - sel0: t = x1
  - sel1: t = (x1Q, −x1I)
  - sel2: r = ((x1I+x1Q)·c, (x1Q−x1I)·c), t = r
  - sel3: t = (rQ, −rI)
- Inverse: complex conjugate of the forward twiddle, same sel order.
  - sel1: t = (−x1Q, x1I)
  - sel2: r = ((x1I−x1Q)·c, (x1Q+x1I)·c)
  - sel3: t = (−rQ, rI)
- c = 181, 9-bit signed, 1 integer bit (≈0.70703).
- Product is NBW_IN+1+9 bits, reduced to NBW_IN/NBI_IN by round-half-to-+inf (floor(x+0.5)) with saturation.
- Sums are NBW_IN+1 bits and exact.
- Output reduction:
  - If NBW_OUT=NBW_IN+1 and NBI_OUT=NBI_IN+1: outputs pass through exact.
  - Otherwise: rnd_sat with RND_INF.
- All lanes share sel and direction.

## Timing
- Two register stages, latency 2.
  - Stage 1 registers x0, the trivial-path t and the products.
  - Stage 2 does round/saturate of r, add/sub, output reduction, then registers.
- o_valid and o_sof are i_valid and i_sof delayed 2 cycles.
- Stage registers load only on valid; o_data holds its last value while o_valid=0.
- Beats may be back-to-back or have gaps; gaps do not advance the counter.
- Reset values: o_valid=0, o_sof=0, o_data=0, o_sat=0, count=0, inv_q=0, pipeline contents 0.
- Reset mid-frame flushes in-flight beats (no output). The next valid beat without sof uses count 0, forward.
- i_sof without i_valid is ignored.
- Mid-frame i_sof restarts the counter immediately; in-flight beats complete with their original sel and direction.

## Configuration
- Macro: FE_BF2II_PIPE_SAT_FLAG_EN.
- Defined:
  - o_sat exists. A beat's saturation event is any saturation in the twiddle rnd_sat or the output rnd_sat of any lane.
  - On an output beat with o_sof: o_sat ← that beat's event.
  - On other output beats: o_sat ← o_sat | event.
  - o_sat updates in the same cycle as o_data and holds between beats.
- Undefined: the o_sat port and all detection logic are absent; datapath behaviour is identical.

## Test plan
Defaults unless noted; NCH=1, forward. Pairs below are (I, Q) in LSB units. First beat of each scenario carries i_sof.
- Sel sweep: x0=(64,0), x1=(32,0) for 4 beats, i_inv=0 → at cycles +2..+5:
  - beat 1: y0=(96,0), y1=(32,0)
  - beat 2: y0=(64,−32), y1=(64,32)
  - beat 3: y0=(87,−23), y1=(41,23)
  - beat 4: y0=(41,−23), y1=(87,23)
- Inverse: same stimulus, i_inv=1 → beat 2: y0=(64,32), y1=(64,−32); inv_q persists over the frame with i_inv toggling on non-sof beats.
- Gaps/wrap: 6 beats with i_valid gaps, no second sof → sel sequence 0,1,2,3,0,1; o_valid pattern equals i_valid delayed 2.
- Resync/reset: sof on beat 3 → that beat sel0. Assert rst_async_n low mid-frame → o_valid=0 and o_data=0 immediately; first beat after release uses sel0, forward.
- Saturation (macro on): x1=(−128,−128) at sel2, x0=0 → y0=(−128,0); o_sat=1 until the next o_sof beat without saturation, then o_sat=0.
- Trim/lanes: NBW_OUT=8, NBI_OUT=1, NCH=2, x0=(127,0), x1=(127,0), sel0 → y0 saturates to (127,0) in both lanes; lane 1 driven with distinct data is independent.

Source files
------------

// File: rtl/fe_bf2ii_pipe.sv
// Pipelined radix-2^2 BF2II butterfly: NCH lanes, twiddles W0/-j/W1/W3 from a frame-aligned counter, latency 2.
// Optional sticky saturation flag o_sat when FE_BF2II_PIPE_SAT_FLAG_EN is defined. RND_INF: 0 = half to +inf, 1 = half away from zero.
module fe_bf2ii_pipe #(
  parameter int NBW_IN  = 8,
  parameter int NBI_IN  = 1,
  parameter int NBW_OUT = NBW_IN + 1,
  parameter int NBI_OUT = NBI_IN + 1,
  parameter int NCH     = 1,
  parameter int NBW_C   = 2,
  parameter int BSEL    = 1,
  parameter int RND_INF = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_async_n,
  input  logic                                    i_valid,
  input  logic                                    i_sof,
  input  logic                                    i_inv,
  input  logic [NCH-1:0][1:0][1:0][NBW_IN-1:0]    i_data,
  output logic                                    o_valid,
  output logic                                    o_sof,
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
  output logic                                    o_sat,
`endif
  output logic [NCH-1:0][1:0][1:0][NBW_OUT-1:0]   o_data
);

  // Beats are accepted on every cycle with i_valid high; there is no backpressure.
  // Data layout: [lane][pair: 1=x0/y0, 0=x1/y1][comp: 1=I, 0=Q].
  localparam int SW   = NBW_IN + 1;
  localparam int PW   = SW + 9;
  localparam int FS   = NBW_IN - NBI_IN;
  localparam int FO   = NBW_OUT - NBI_OUT;
  localparam int UP   = (FO > FS) ? FO - FS : 0;
  localparam int DN   = (FS > FO) ? FS - FO : 0;
  localparam int HALF = (1 << DN) >> 1;
  localparam int EW0  = SW + UP + 1;
  localparam int EW   = (EW0 > NBW_OUT + 1) ? EW0 : NBW_OUT + 1;
  localparam logic signed [8:0] C_TW = 9'sd181;

  // Drops the 8 coefficient fraction bits with floor(x+0.5), then saturates to NBW_IN.
  function automatic logic [NBW_IN:0] tw_rnd(input logic signed [PW-1:0] p);
    logic signed [PW:0] sh;
    logic               sat;
    sh  = ((PW+1)'(p) + (PW+1)'(128)) >>> 8;
    sat = ~(&sh[PW:NBW_IN-1]) & (|sh[PW:NBW_IN-1]);
    return {sat, sat ? {sh[PW], {(NBW_IN-1){~sh[PW]}}} : sh[NBW_IN-1:0]};
  endfunction

  function automatic logic [NBW_OUT:0] out_rnd(input logic signed [SW-1:0] s);
    logic signed [EW-1:0] e;
    logic                 sat;
    e = EW'(s) <<< UP;
    if (DN > 0) begin
      e = e + EW'(HALF) - (((RND_INF != 0) && s[SW-1]) ? EW'(1) : EW'(0));
      e = e >>> DN;
    end
    sat = ~(&e[EW-1:NBW_OUT-1]) & (|e[EW-1:NBW_OUT-1]);
    return {sat, sat ? {e[EW-1], {(NBW_OUT-1){~e[EW-1]}}} : e[NBW_OUT-1:0]};
  endfunction

  logic [NBW_C-1:0] count_q, cnt_use;
  logic             inv_q, inv_use;
  logic [1:0]       sel_use;

  // A valid sof beat uses count 0 and its own i_inv for itself, not only for later beats.
  assign cnt_use = i_sof ? '0 : count_q;
  assign sel_use = cnt_use[BSEL:BSEL-1];
  assign inv_use = i_sof ? i_inv : inv_q;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      count_q <= '0;
      inv_q   <= 1'b0;
    end else if (i_valid) begin
      count_q <= cnt_use + 1'b1;
      if (i_sof) inv_q <= i_inv;
    end
  end

  logic [NCH-1:0][1:0][NBW_IN-1:0] x0_d, x0_q;
  logic [NCH-1:0][1:0][SW-1:0]     t_d, t_q;
  logic [NCH-1:0][1:0][PW-1:0]     p_d, p_q;
  logic                            v1_q, sof1_q, inv1_q;
  logic [1:0]                      sel1_q;

  for (genvar l = 0; l < NCH; l++) begin : g_s1
    logic signed [SW-1:0] x1i, x1q, ai, aq;
    assign x1i = SW'($signed(i_data[l][0][1]));
    assign x1q = SW'($signed(i_data[l][0][0]));
    assign x0_d[l] = i_data[l][1];
    // Trivial path: identity for sel0, -j (or +j inverse) for sel1.
    assign t_d[l][1] = ~sel_use[0] ? x1i : (inv_use ? -x1q : x1q);
    assign t_d[l][0] = ~sel_use[0] ? x1q : (inv_use ? x1i : -x1i);
    assign ai = inv_use ? x1i - x1q : x1i + x1q;
    assign aq = inv_use ? x1q + x1i : x1q - x1i;
    assign p_d[l][1] = PW'(ai) * PW'(C_TW);
    assign p_d[l][0] = PW'(aq) * PW'(C_TW);
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      sel1_q <= '0;
      inv1_q <= 1'b0;
      x0_q   <= '0;
      t_q    <= '0;
      p_q    <= '0;
    end else begin
      v1_q   <= i_valid;
      sof1_q <= i_valid & i_sof;
      if (i_valid) begin
        sel1_q <= sel_use;
        inv1_q <= inv_use;
        x0_q   <= x0_d;
        t_q    <= t_d;
        p_q    <= p_d;
      end
    end
  end

  logic [NCH-1:0][1:0][1:0][NBW_OUT-1:0] data_d;
  logic [NCH-1:0]                        lane_ev;

  for (genvar l = 0; l < NCH; l++) begin : g_s2
    logic [NBW_IN:0]      ri_s, rq_s;
    logic signed [SW-1:0] ri, rq, twi, twq, ti, tq, x0i, x0q;
    logic signed [SW-1:0] y0i, y0q, y1i, y1q;
    logic [NBW_OUT:0]     o0i, o0q, o1i, o1q;
    assign ri_s = tw_rnd($signed(p_q[l][1]));
    assign rq_s = tw_rnd($signed(p_q[l][0]));
    assign ri   = SW'($signed(ri_s[NBW_IN-1:0]));
    assign rq   = SW'($signed(rq_s[NBW_IN-1:0]));
    // W3 is the W1 product rotated by -j (forward) or +j (inverse) after rounding.
    assign twi  = ~sel1_q[0] ? ri : (inv1_q ? -rq : rq);
    assign twq  = ~sel1_q[0] ? rq : (inv1_q ? ri : -ri);
    assign ti   = sel1_q[1] ? twi : $signed(t_q[l][1]);
    assign tq   = sel1_q[1] ? twq : $signed(t_q[l][0]);
    assign x0i  = SW'($signed(x0_q[l][1]));
    assign x0q  = SW'($signed(x0_q[l][0]));
    assign y0i  = x0i + ti;
    assign y0q  = x0q + tq;
    assign y1i  = x0i - ti;
    assign y1q  = x0q - tq;
    assign o0i  = out_rnd(y0i);
    assign o0q  = out_rnd(y0q);
    assign o1i  = out_rnd(y1i);
    assign o1q  = out_rnd(y1q);
    assign data_d[l][1][1] = o0i[NBW_OUT-1:0];
    assign data_d[l][1][0] = o0q[NBW_OUT-1:0];
    assign data_d[l][0][1] = o1i[NBW_OUT-1:0];
    assign data_d[l][0][0] = o1q[NBW_OUT-1:0];
    assign lane_ev[l] = (sel1_q[1] & (ri_s[NBW_IN] | rq_s[NBW_IN])) |
                        o0i[NBW_OUT] | o0q[NBW_OUT] | o1i[NBW_OUT] | o1q[NBW_OUT];
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= v1_q;
      o_sof   <= sof1_q;
      if (v1_q) o_data <= data_d;
    end
  end

`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
  // Sticky over a frame; a sof output beat restarts it with its own event.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      o_sat <= 1'b0;
    end else if (v1_q) begin
      o_sat <= sof1_q ? (|lane_ev) : (o_sat | (|lane_ev));
    end
  end
`else
  logic ev_unused;
  assign ev_unused = |lane_ev;
`endif

endmodule

// File: tb/tb_fe_bf2ii_pipe.sv
// Randomized + directed bench for fe_bf2ii_pipe: default instance (9-bit exact out) and a trimmed two-lane instance.
// Expected outputs come from a complex-arithmetic reference model; o_sat is checked when FE_BF2II_PIPE_SAT_FLAG_EN is defined.
module tb_fe_bf2ii_pipe;

  localparam int NBW_C = 2;
  localparam int BSEL  = 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic i_valid, i_sof, i_inv;
  logic [0:0][1:0][1:0][7:0] di_a;
  logic [1:0][1:0][1:0][7:0] di_b;
  logic [0:0][1:0][1:0][8:0] do_a;
  logic [1:0][1:0][1:0][7:0] do_b;
  logic ov_a, os_a, ov_b, os_b;
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
  logic sat_a, sat_b;
`endif

  fe_bf2ii_pipe dut_a (
    .clk(clk), .rst_async_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_inv(i_inv),
    .i_data(di_a), .o_valid(ov_a), .o_sof(os_a),
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
    .o_sat(sat_a),
`endif
    .o_data(do_a)
  );

  fe_bf2ii_pipe #(.NBW_OUT(8), .NBI_OUT(1), .NCH(2)) dut_b (
    .clk(clk), .rst_async_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_inv(i_inv),
    .i_data(di_b), .o_valid(ov_b), .o_sof(os_b),
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
    .o_sat(sat_b),
`endif
    .o_data(do_b)
  );

  // Scoreboard state
  logic [35:0] exp_qa[$];
  logic [63:0] exp_qb[$];
  bit          sat_qa[$], sat_qb[$];
  logic [35:0] last_a, ea;
  logic [63:0] last_b, eb;
  bit          sa, sb;
  int n_chk = 0;
  int n_fail = 0;

  int m_cnt;
  bit m_inv, m_sat_a, m_sat_b;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: complex arithmetic on integers in LSB units
  function automatic void cmul(input int a, input int b, input int c, input int d,
                               output int re, output int im);
    re = a * c - b * d;
    im = a * d + b * c;
  endfunction

  function automatic int tw_rs(input int v, output bit sat);
    int n, q;
    n = v * 181 + 128;
    q = (n >= 0) ? n / 256 : -((-n + 255) / 256);
    sat = 1'b0;
    if (q > 127)  begin q = 127;  sat = 1'b1; end
    if (q < -128) begin q = -128; sat = 1'b1; end
    return q;
  endfunction

  function automatic int sat8(input int v, inout bit s);
    if (v > 127)  begin s = 1'b1; return 127;  end
    if (v < -128) begin s = 1'b1; return -128; end
    return v;
  endfunction

  task automatic model_lane(input int x0i, input int x0q, input int x1i, input int x1q,
                            input int sel, input bit inv,
                            output int y0i, output int y0q, output int y1i, output int y1q,
                            output bit tsat);
    int ti, tq, mi, mq, ri, rq, rot;
    bit s1, s2;
    rot = inv ? 1 : -1;
    tsat = 1'b0;
    if (sel == 0) begin
      ti = x1i; tq = x1q;
    end else if (sel == 1) begin
      cmul(x1i, x1q, 0, rot, ti, tq);
    end else begin
      cmul(x1i, x1q, 1, rot, mi, mq);
      ri = tw_rs(mi, s1);
      rq = tw_rs(mq, s2);
      tsat = s1 | s2;
      if (sel == 2) begin ti = ri; tq = rq; end
      else cmul(ri, rq, 0, rot, ti, tq);
    end
    y0i = x0i + ti; y0q = x0q + tq;
    y1i = x0i - ti; y1q = x0q - tq;
  endtask

  function automatic logic [35:0] pk9(input int a, input int b, input int c, input int d);
    return {9'(a), 9'(b), 9'(c), 9'(d)};
  endfunction

  function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  // Driver: one valid beat; lane 0 (x*) feeds both DUTs, lane 1 (u*) only dut_b
  task automatic beat(input bit sof, input bit inv,
                      input int x0i, input int x0q, input int x1i, input int x1q,
                      input int u0i, input int u0q, input int u1i, input int u1q,
                      input bit ovr, input logic [35:0] ca, input logic [63:0] cb);
    int cu, sel, y[4], z[4];
    bit iu, t0, t1, os, ev_a, ev_b;
    @(negedge clk);
    i_valid = 1'b1; i_sof = sof; i_inv = inv;
    di_a = pk8(x0i, x0q, x1i, x1q);
    di_b = {pk8(u0i, u0q, u1i, u1q), pk8(x0i, x0q, x1i, x1q)};
    cu = sof ? 0 : m_cnt;
    sel = (cu >> (BSEL - 1)) % 4;
    m_cnt = (cu + 1) % (1 << NBW_C);
    iu = sof ? inv : m_inv;
    if (sof) m_inv = inv;
    model_lane(x0i, x0q, x1i, x1q, sel, iu, y[0], y[1], y[2], y[3], t0);
    model_lane(u0i, u0q, u1i, u1q, sel, iu, z[0], z[1], z[2], z[3], t1);
    os = 1'b0;
    ev_a = t0;
    eb = {pk8(sat8(z[0], os), sat8(z[1], os), sat8(z[2], os), sat8(z[3], os)),
          pk8(sat8(y[0], os), sat8(y[1], os), sat8(y[2], os), sat8(y[3], os))};
    ev_b = t0 | t1 | os;
    m_sat_a = sof ? ev_a : (m_sat_a | ev_a);
    m_sat_b = sof ? ev_b : (m_sat_b | ev_b);
    exp_qa.push_back(ovr ? ca : pk9(y[0], y[1], y[2], y[3]));
    exp_qb.push_back(ovr ? cb : eb);
    sat_qa.push_back(m_sat_a);
    sat_qb.push_back(m_sat_b);
  endtask

  task automatic rbeat(input bit sof, input bit inv);
    beat(sof, inv, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
         $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
         $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
         $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_sof = 1'($urandom_range(0, 1));
      i_inv = 1'($urandom_range(0, 1));
      di_a = 32'($urandom);
      di_b = {32'($urandom), 32'($urandom)};
    end
  endtask

  // Expected o_valid / o_sof: accepted beats delayed two cycles
  logic v1, v2, s1, s2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; s1 <= 1'b0; s2 <= 1'b0;
    end else begin
      v1 <= i_valid; v2 <= v1;
      s1 <= i_valid & i_sof; s2 <= s1;
    end
  end

  // Scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_val("valid_a", 64'(ov_a), 64'(v2));
      check_val("valid_b", 64'(ov_b), 64'(v2));
      check_val("sof_a", 64'(os_a), 64'(s2));
      check_val("sof_b", 64'(os_b), 64'(s2));
      if (ov_a) begin
        if (exp_qa.size() == 0) check_val("extra_a", 64'(1), 64'(0));
        else begin
          ea = exp_qa.pop_front(); sa = sat_qa.pop_front();
          check_val("data_a", 64'(do_a), 64'(ea));
          last_a = ea;
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
          check_val("sat_a", 64'(sat_a), 64'(sa));
`endif
        end
      end else check_val("hold_a", 64'(do_a), 64'(last_a));
      if (ov_b) begin
        if (exp_qb.size() == 0) check_val("extra_b", 64'(1), 64'(0));
        else begin
          eb = exp_qb.pop_front(); sb = sat_qb.pop_front();
          check_val("data_b", do_b, eb);
          last_b = eb;
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
          check_val("sat_b", 64'(sat_b), 64'(sb));
`endif
        end
      end else check_val("hold_b", do_b, last_b);
    end
  end

  task automatic model_reset();
    exp_qa.delete(); exp_qb.delete(); sat_qa.delete(); sat_qb.delete();
    last_a = '0; last_b = '0;
    m_cnt = 0; m_inv = 1'b0; m_sat_a = 1'b0; m_sat_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_inv = 1'b0; di_a = '0; di_b = '0;
    model_reset();
    #12;
    check_val("rst_valid", 64'({ov_a, ov_b, os_a, os_b}), 64'(0));
    check_val("rst_data", {28'(do_a), 36'(do_b)}, 64'(0));
`ifdef FE_BF2II_PIPE_SAT_FLAG_EN
    check_val("rst_sat", 64'({sat_a, sat_b}), 64'(0));
`endif
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Sel sweep, forward
    beat(1, 0, 64, 0, 32, 0, 10, 5, -3, 7, 1, pk9(96, 0, 32, 0), {pk8(7, 12, 13, -2), pk8(96, 0, 32, 0)});
    beat(0, 0, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(64, -32, 64, 32), 64'(pk8(64, -32, 64, 32)));
    beat(0, 0, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(87, -23, 41, 23), 64'(pk8(87, -23, 41, 23)));
    beat(0, 0, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(41, -23, 87, 23), 64'(pk8(41, -23, 87, 23)));
    idle(1);

    // Inverse frame; i_inv toggles on non-sof beats and must be ignored
    beat(1, 1, 64, 0, 32, 0, 0, 0, 0, 0, 0, '0, '0);
    beat(0, 0, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(64, 32, 64, -32), 64'(pk8(64, 32, 64, -32)));
    beat(0, 1, 64, 0, 32, 0, 0, 0, 0, 0, 0, '0, '0);
    beat(0, 0, 64, 0, 32, 0, 0, 0, 0, 0, 0, '0, '0);

    // Gaps and counter wrap
    rbeat(1, 0);
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 2));
      rbeat(0, 1'($urandom_range(0, 1)));
    end

    // Mid-frame resync on beat 3
    beat(1, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, '0, '0);
    rbeat(0, 0);
    beat(1, 0, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(96, 0, 32, 0), 64'(pk8(96, 0, 32, 0)));
    rbeat(0, 0);

    // Saturation in the W1 product, then a clean frame
    beat(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    beat(0, 0, 0, 0, -128, -128, 0, 0, 0, 0, 1, pk9(-128, 0, 128, 0), 64'(pk8(-128, 0, 127, 0)));
    beat(0, 0, 3, 3, 5, 5, 0, 0, 0, 0, 0, '0, '0);
    beat(1, 0, 3, 3, 5, 5, 1, 1, 1, 1, 0, '0, '0);
    idle(1);

    // Trim saturation and lane independence
    beat(1, 0, 127, 0, 127, 0, -20, 10, 5, -7, 1, pk9(254, 0, 0, 0),
         {pk8(-15, 3, -25, 17), pk8(127, 0, 0, 0)});
    idle(1);

    // Reset mid-frame with outputs active
    beat(1, 1, 20, 20, 30, 30, 0, 0, 0, 0, 0, '0, '0);
    rbeat(0, 0);
    rbeat(0, 0);
    @(posedge clk); #2;
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 64'({ov_a, ov_b}), 64'(0));
    check_val("midrst_data", {28'(do_a), 36'(do_b)}, 64'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    beat(0, 1, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(96, 0, 32, 0), 64'(pk8(96, 0, 32, 0)));
    beat(0, 1, 64, 0, 32, 0, 0, 0, 0, 0, 1, pk9(64, -32, 64, 32), 64'(pk8(64, -32, 64, 32)));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      rbeat($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end

    // Drain with a bounded wait
    idle(1);
    for (int i = 0; i < 10 && (exp_qa.size() + exp_qb.size()) != 0; i++) idle(1);
    check_val("drain", 64'(exp_qa.size() + exp_qb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
